// File: rtl/fp_pkg.sv
// Shared FP32 constants, FSM state type and special-operand decode for the sequential divider.
package fp_pkg;

  localparam int EXP_W    = 8;
  localparam int MANT_W   = 23;
  localparam int EXP_BIAS = 127;
  localparam int QBITS    = 25;

  localparam logic [31:0] QNAN    = 32'h7FC00000;
  localparam logic [31:0] POS_INF = 32'h7F800000;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CALC,
    ST_NORM,
    ST_DONE
  } state_t;

  typedef struct packed {
    logic        hit;
    logic        dbz;
    logic [31:0] res;
  } special_t;

  // Subnormals are treated as zero; the branch order below is the priority order.
  function automatic special_t fp_special(input logic [31:0] a, input logic [31:0] b);
    special_t s;
    logic sg, z1, z2, i1, i2, n1, n2;
    sg = a[31] ^ b[31];
    z1 = (a[30:23] == 8'h00);
    z2 = (b[30:23] == 8'h00);
    i1 = (a[30:23] == 8'hFF) && (a[22:0] == 23'h0);
    i2 = (b[30:23] == 8'hFF) && (b[22:0] == 23'h0);
    n1 = (a[30:23] == 8'hFF) && (a[22:0] != 23'h0);
    n2 = (b[30:23] == 8'hFF) && (b[22:0] != 23'h0);
    s.hit = 1'b1;
    s.dbz = 1'b0;
    s.res = QNAN;
    if (n1 || n2) begin
      s.res = QNAN;
    end else if ((i1 && i2) || (z1 && z2)) begin
      s.res = QNAN;
    end else if (z2 && !i1) begin
      s.res = {sg, POS_INF[30:0]};
      s.dbz = 1'b1;
    end else if (i1) begin
      s.res = {sg, POS_INF[30:0]};
    end else if (z1 || i2) begin
      s.res = {sg, 31'h0};
    end else begin
      s.hit = 1'b0;
    end
    return s;
  endfunction

endpackage

// File: rtl/mant_div_core.sv
// Restoring mantissa divider: one quotient bit per cycle for QBITS cycles after start.
module mant_div_core
  import fp_pkg::*;
(
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             start_i,
  input  logic [23:0]      ma_i,
  input  logic [23:0]      mb_i,
  output logic             done_o,
  output logic [QBITS-1:0] q_o
);

  logic [25:0]      rem_q, rem_d;
  logic [23:0]      mb_q;
  logic [QBITS-1:0] q_q, q_d;
  logic [4:0]       cnt_q;
  logic             busy_q, done_q;
  logic [25:0]      diff;
  logic             ge;

  assign diff = rem_q - {2'b00, mb_q};
  assign ge   = (rem_q >= {2'b00, mb_q});

  always_comb begin
    rem_d = rem_q;
    q_d   = q_q;
    if (start_i) begin
      rem_d = {2'b00, ma_i};
      q_d   = '0;
    end else if (busy_q) begin
      if (ge) begin
        q_d   = {q_q[QBITS-2:0], 1'b1};
        rem_d = {diff[24:0], 1'b0};
      end else begin
        q_d   = {q_q[QBITS-2:0], 1'b0};
        rem_d = {rem_q[24:0], 1'b0};
      end
    end
  end

  // Datapath registers carry no reset; busy/done gate their use.
  always_ff @(posedge clk_i) begin
    rem_q <= rem_d;
    q_q   <= q_d;
    if (start_i) mb_q <= mb_i;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      busy_q <= 1'b0;
      done_q <= 1'b0;
      cnt_q  <= '0;
    end else begin
      done_q <= 1'b0;
      if (start_i) begin
        busy_q <= 1'b1;
        cnt_q  <= '0;
      end else if (busy_q) begin
        if (cnt_q == 5'(QBITS - 1)) begin
          busy_q <= 1'b0;
          done_q <= 1'b1;
        end else begin
          cnt_q <= cnt_q + 5'd1;
        end
      end
    end
  end

  assign done_o = done_q;
  assign q_o    = q_q;

endmodule

// File: rtl/fp_division_seq.sv
// Sequential FP32 divider: special-case decode, exponent math and normalisation around mant_div_core.
module fp_division_seq
  import fp_pkg::*;
(
  input  logic        CLK,
  input  logic        nRST,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] data1,
  input  logic [31:0] data2,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] result,
  output logic        overflow,
  output logic        underflow,
  output logic        div_by_zero
);

  state_t             state_q, state_d;
  logic               sign_q, sign_d;
  logic signed [9:0]  expt_q, expt_d;
  logic [31:0]        result_q, result_d;
  logic               ovf_q, ovf_d, unf_q, unf_d, dbz_q, dbz_d;
  logic               core_start, core_done;
  logic [QBITS-1:0]   core_q;
  special_t           spec;
  logic signed [9:0]  exp_in, exp_n;
  logic [22:0]        mant_n;

  assign spec   = fp_special(data1, data2);
  assign exp_in = $signed({2'b00, data1[30:23]}) - $signed({2'b00, data2[30:23]})
                  + 10'sd127;

  mant_div_core u_core (
    .clk_i   (CLK),
    .rst_ni  (nRST),
    .start_i (core_start),
    .ma_i    ({1'b1, data1[22:0]}),
    .mb_i    ({1'b1, data2[22:0]}),
    .done_o  (core_done),
    .q_o     (core_q)
  );

  // A quotient below 1.0 leaves its leading one in bit 23 and borrows one from the exponent.
  always_comb begin
    if (core_q[QBITS-1]) begin
      mant_n = core_q[23:1];
      exp_n  = expt_q;
    end else begin
      mant_n = core_q[22:0];
      exp_n  = expt_q - 10'sd1;
    end
  end

  always_comb begin
    state_d    = state_q;
    sign_d     = sign_q;
    expt_d     = expt_q;
    result_d   = result_q;
    ovf_d      = ovf_q;
    unf_d      = unf_q;
    dbz_d      = dbz_q;
    core_start = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          sign_d = data1[31] ^ data2[31];
          expt_d = exp_in;
          ovf_d  = 1'b0;
          unf_d  = 1'b0;
          dbz_d  = 1'b0;
          if (spec.hit) begin
            result_d = spec.res;
            dbz_d    = spec.dbz;
            state_d  = ST_DONE;
          end else begin
            core_start = 1'b1;
            state_d    = ST_CALC;
          end
        end
      end
      ST_CALC: begin
        if (core_done) state_d = ST_NORM;
      end
      ST_NORM: begin
        if (exp_n >= 10'sd255) begin
          result_d = {sign_q, POS_INF[30:0]};
          ovf_d    = 1'b1;
        end else if (exp_n <= 10'sd0) begin
          result_d = {sign_q, 31'h0};
          unf_d    = 1'b1;
        end else begin
          result_d = {sign_q, exp_n[7:0], mant_n};
        end
        state_d = ST_DONE;
      end
      ST_DONE: begin
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    sign_q <= sign_d;
    expt_q <= expt_d;
  end

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state_q  <= ST_IDLE;
      result_q <= '0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
      dbz_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
      dbz_q    <= dbz_d;
    end
  end

  assign in_ready    = (state_q == ST_IDLE);
  assign out_valid   = (state_q == ST_DONE);
  assign result      = result_q;
  assign overflow    = ovf_q;
  assign underflow   = unf_q;
  assign div_by_zero = dbz_q;

endmodule
